// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared frame geometry and FSM encoding for the edge frame writer
package edge_pkg;

  localparam int WIDTH_DEF  = 64;
  localparam int HEIGHT_DEF = 64;
  localparam int N_PIX      = WIDTH_DEF * HEIGHT_DEF;
  localparam int ADDR_W     = $clog2(N_PIX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2,
    READOUT = 2'd3
  } state_t;

endpackage

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - simple dual-port frame RAM, one write port, one registered read port, no reset
module frame_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/edge_frame_writer.sv
// rtl/edge_frame_writer.sv - captures one edge-pixel frame into RAM and replays it over a valid/ready stream
// Build option: EDGE_THRESH_EN stores a binary edge map (pix_data >= THRESH -> 8'hFF, else 8'h00).
module edge_frame_writer
  import edge_pkg::*;
#(
  parameter int         WIDTH  = WIDTH_DEF,
  parameter int         HEIGHT = HEIGHT_DEF,
  parameter logic [7:0] THRESH = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  input  logic       pix_sof,
  input  logic [7:0] pix_data,
  input  logic       rd_start,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_done,
  output logic       busy,
  output logic       overflow
);

  localparam int            N    = WIDTH * HEIGHT;
  localparam int            AW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_t        state, state_n;
  logic [AW-1:0] wr_addr, rd_addr, waddr;
  logic [7:0]    wdata, q;
  logic          we, re;
  logic          q_valid, q_last, rd_all;
  logic          hs, load_out, rd_accept, drop, realign;

`ifdef EDGE_THRESH_EN
  assign wdata = (pix_data >= THRESH) ? 8'hFF : 8'h00;
`else
  // THRESH is masked out so both builds keep one parameter list
  assign wdata = pix_data | (THRESH & 8'h00);
`endif

  assign busy = (state == CAPTURE) || (state == READOUT);

  always_comb begin
    state_n   = state;
    we        = 1'b0;
    waddr     = wr_addr;
    re        = 1'b0;
    rd_accept = 1'b0;
    drop      = 1'b0;
    realign   = 1'b0;
    hs        = out_valid && out_ready;
    load_out  = q_valid && (!out_valid || out_ready);
    case (state)
      IDLE: begin
        if (pix_valid && pix_sof) begin
          we      = 1'b1;
          waddr   = '0;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (pix_valid) begin
          we = 1'b1;
          if (pix_sof) begin
            waddr   = '0;
            realign = 1'b1;
          end else if (wr_addr == LAST) begin
            state_n = FULL;
          end
        end
      end
      FULL: begin
        drop = pix_valid;
        if (rd_start) begin
          rd_accept = 1'b1;
          state_n   = READOUT;
        end
      end
      READOUT: begin
        drop = pix_valid;
        // Read only when the RAM output slot is free next cycle: keeps 1 pixel/cycle and holds under stall
        re   = !rd_all && (!q_valid || load_out);
        if (hs && out_last) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_addr    <= '0;
      rd_addr    <= '0;
      rd_all     <= 1'b0;
      q_valid    <= 1'b0;
      q_last     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= (state == CAPTURE) && (state_n == FULL);

      if (we) begin
        wr_addr <= (waddr == LAST) ? '0 : waddr + ONE;
      end

      if (rd_accept) begin
        overflow <= 1'b0;
      end
      if (drop || realign) begin
        overflow <= 1'b1;
      end

      if (re) begin
        rd_addr <= (rd_addr == LAST) ? rd_addr : rd_addr + ONE;
        rd_all  <= (rd_addr == LAST);
        q_last  <= (rd_addr == LAST);
        q_valid <= 1'b1;
      end else if (load_out) begin
        q_valid <= 1'b0;
      end

      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= q;
        out_last  <= q_last;
      end else if (hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (rd_accept || (state == READOUT && state_n == IDLE)) begin
        rd_addr   <= '0;
        rd_all    <= 1'b0;
        q_valid   <= 1'b0;
        q_last    <= 1'b0;
      end
    end
  end

  frame_ram #(
    .DEPTH(N),
    .AW   (AW)
  ) u_frame_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re),
    .raddr(rd_addr),
    .rdata(q)
  );

endmodule

// File: tb/tb_edge_frame_writer.sv
// tb/tb_edge_frame_writer.sv - directed self-checking bench for edge_frame_writer
module tb_edge_frame_writer;

  localparam int N = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       rd_start = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_done;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  edge_frame_writer dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_data  (pix_data),
    .rd_start  (rd_start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_done(frame_done),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] expv(input int v);
    logic [7:0] b;
    b = v[7:0];
`ifdef EDGE_THRESH_EN
    return (b >= 8'd64) ? 8'hFF : 8'h00;
`else
    return b;
`endif
  endfunction

  // Pixel i of the frame carries (i+off); prefix>0 sends a partial frame first so the real frame realigns it
  task automatic send_frame(input int off, input int gap, input int prefix, input bit rd_mid);
    int fd_bad = 0;
    int flag_bad = 0;
    for (int i = 0; i < prefix; i++) begin
      pix_valid = 1'b1; pix_sof = (i == 0); pix_data = 8'(i ^ 8'h55);
      step();
      if (frame_done !== 1'b0) fd_bad++;
    end
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        pix_valid = 1'b0; pix_sof = 1'b0;
        step();
        if (frame_done !== 1'b0) fd_bad++;
      end
      pix_valid = 1'b1; pix_sof = (i == 0); pix_data = 8'(i + off);
      rd_start = rd_mid && (i == 50);
      step();
      rd_start = 1'b0;
      if (frame_done !== (i == N - 1)) fd_bad++;
      if (out_valid !== 1'b0) flag_bad++;
      if (i < N - 1 && busy !== 1'b1) flag_bad++;
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    step();
    checks++;
    if (fd_bad != 0) begin
      failures++; $display("FAIL frame_done_timing: bad_cycles=%0d required=0", fd_bad);
    end
    checks++;
    if (flag_bad != 0) begin
      failures++; $display("FAIL capture_flags: bad_cycles=%0d required=0", flag_bad);
    end
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL full_state: frame_done=%0b busy=%0b required 0 0", frame_done, busy);
    end
  endtask

  task automatic read_frame(input int off, input bit rnd, input int stop_at, input bit inject);
    int beat = 0;
    int bad_data = 0;
    int bad_last = 0;
    int bad_hold = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit done = 1'b0;
    bit lat_ok;
    logic [7:0] held = 8'h00;
    out_ready = 1'b0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL overflow_clear: got=%0b required=0", overflow);
    end
    lat_ok = (out_valid === 1'b0);
    step();
    lat_ok = lat_ok && (out_valid === 1'b0);
    step();
    lat_ok = lat_ok && (out_valid === 1'b1);
    checks++;
    if (!lat_ok) begin
      failures++; $display("FAIL first_valid_latency: out_valid=%0b not rising exactly 2 cycles after rd_start", out_valid);
    end
    while (!done && cyc < 20000) begin
      cyc++;
      if (stalled && (out_valid !== 1'b1 || out_data !== held)) bad_hold++;
      if (stop_at >= 0 && beat == stop_at) begin
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          failures++; $display("FAIL reset_mid_readout: out_valid=%0b busy=%0b required 0 0", out_valid, busy);
        end
        done = 1'b1;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_valid = inject && out_valid && out_ready && (beat == 10 || beat == N - 1);
        pix_sof = pix_valid;
        pix_data = 8'hAA;
        if (out_valid && out_ready) begin
          if (out_data !== expv(beat + off)) bad_data++;
          if (out_last !== (beat == N - 1)) bad_last++;
          if (beat == N - 1) done = 1'b1;
          beat++;
        end
        stalled = out_valid && !out_ready;
        held = out_data;
        step();
        pix_valid = 1'b0; pix_sof = 1'b0;
      end
    end
    out_ready = 1'b0;
    checks++;
    if (!done) begin
      failures++; $display("FAIL readout_timeout: beats=%0d required=%0d", beat, N);
    end
    checks++;
    if (bad_data != 0 || bad_hold != 0) begin
      failures++; $display("FAIL readout_data: bad_data=%0d bad_hold=%0d required 0 0", bad_data, bad_hold);
    end
    checks++;
    if (bad_last != 0) begin
      failures++; $display("FAIL readout_last: bad_beats=%0d required=0", bad_last);
    end
    if (stop_at < 0) begin
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL readout_end: out_valid=%0b busy=%0b required 0 0", out_valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      failures++; $display("FAIL reset_out: out_valid=%0b out_last=%0b required 0 0", out_valid, out_last);
    end
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL reset_flags: fd=%0b busy=%0b ovf=%0b required 0 0 0", frame_done, busy, overflow);
    end
    rst = 1'b0;
    pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 8'h12;
    repeat (5) step();
    pix_valid = 1'b0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL idle_ignore: busy=%0b ovf=%0b out_valid=%0b required 0 0 0", busy, overflow, out_valid);
    end
  endtask

  task automatic test_ramp();
    send_frame(0, 0, 0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL ramp_overflow: got=%0b required=0", overflow);
    end
    read_frame(0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    send_frame(63, 0, 0, 1'b0);
    read_frame(63, 1'b1, -1, 1'b0);
  endtask

  task automatic test_gapped();
    send_frame(9, 2, 0, 1'b1);
    read_frame(9, 1'b0, -1, 1'b0);
  endtask

  task automatic test_midframe_sof();
    send_frame(17, 0, 100, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      failures++; $display("FAIL midframe_overflow: got=%0b required=1", overflow);
    end
    read_frame(17, 1'b0, -1, 1'b0);
  endtask

  task automatic test_full_drop();
    send_frame(200, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1; pix_sof = (i % 2 == 0); pix_data = 8'hEE;
      step();
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    step();
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL full_drop: ovf=%0b busy=%0b required 1 0", overflow, busy);
    end
    read_frame(200, 1'b0, -1, 1'b1);
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL readout_drop: ovf=%0b busy=%0b required 1 0", overflow, busy);
    end
  endtask

  task automatic test_reset_readout();
    send_frame(3, 0, 0, 1'b0);
    read_frame(3, 1'b0, 2000, 1'b0);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: out_valid=%0b busy=%0b required 0 0", out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_gapped();
    test_midframe_sof();
    test_full_drop();
    test_reset_readout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
